// File: rtl/hier_gate_pipe_if.sv
// hier_gate_pipe_if: handshake bundle for hier_gate_pipe.
//   Input side : in_valid, in_ready, in_a, in_b, in_mode (per-beat gate select)
//   Output side: out_valid, out_ready, out_data, out_zero, beat_count
//   master modport: the upstream/downstream environment driving the block.
//   slave  modport: the hier_gate_pipe block itself.
interface hier_gate_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic [15:0]      beat_count;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero, beat_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero, beat_count
  );
endinterface

// File: rtl/hier_gate_pipe.sv
// hier_gate_pipe: per-beat bitwise gate followed by an elastic register pipeline.
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : hier_gate_pipe_if slave modport
//          in_valid/in_ready/in_a/in_b/in_mode  -> input beat
//          out_valid/out_ready/out_data/out_zero -> result beat
//          beat_count                          -> saturating count of delivered beats
// Function per bit: mode 00 ~a&b, 01 a&b, 10 a|b, 11 a^b.
// The result is computed combinationally into stage 1; later stages only carry it.
// Each stage advances when it is empty or the stage after it advances, so
// bubbles collapse and the pipe holds exactly STAGES beats when stalled.
module hier_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic            clk,
  input logic            rst,
  hier_gate_pipe_if.slave bus
);

  logic [STAGES-1:0]            v;
  logic [STAGES-1:0][WIDTH-1:0] d;
  logic [STAGES-1:0]            z;
  logic [STAGES-1:0]            en;
  logic [WIDTH-1:0]             result;
  logic [15:0]                  beat_count_q;
  logic                         out_xfer;

  always_comb begin
    result = '0;
    case (bus.in_mode)
      2'b00: result = ~bus.in_a & bus.in_b;
      2'b01: result = bus.in_a & bus.in_b;
      2'b10: result = bus.in_a | bus.in_b;
      2'b11: result = bus.in_a ^ bus.in_b;
      default: result = '0;
    endcase
  end

  // Unrolled form of en_k = !v_k || en_(k+1): a stage may move if the output
  // is accepted or any stage from it to the tail is empty. Written without
  // self-reference so the enable chain is a plain fan-in of the valid bits.
  always_comb begin
    en = '0;
    for (int k = 0; k < STAGES; k++) begin
      en[k] = bus.out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!v[j]) begin
          en[k] = 1'b1;
        end
      end
    end
  end

  assign bus.in_ready   = en[0] && !rst;
  assign bus.out_valid  = v[STAGES-1];
  assign bus.out_data   = d[STAGES-1];
  assign bus.out_zero   = z[STAGES-1];
  assign bus.beat_count = beat_count_q;
  assign out_xfer       = v[STAGES-1] && bus.out_ready;

  // Empty slots may load don't-care data alongside a cleared valid bit;
  // only valid-qualified contents are ever observed downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      d <= '0;
      z <= '0;
    end else begin
      if (en[0]) begin
        v[0] <= bus.in_valid;
        d[0] <= result;
        z[0] <= (result == '0);
      end
      for (int k = 1; k < STAGES; k++) begin
        if (en[k]) begin
          v[k] <= v[k-1];
          d[k] <= d[k-1];
          z[k] <= z[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count_q <= '0;
    end else if (out_xfer && (beat_count_q != 16'hFFFF)) begin
      beat_count_q <= beat_count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_hier_gate_pipe.sv
// tb_hier_gate_pipe: checks hier_gate_pipe at STAGES = 2, 1 and 4 (WIDTH = 8)
// with one broadcast directed stimulus stream. Each instance has its own
// scoreboard queue: a beat's hand-computed result is queued when that instance
// accepts it, and a monitor pops and compares whenever it delivers a result.
// The monitor also tracks occupancy, beat_count, hold-while-stalled,
// post-reset state and single-beat latency.
module tb_hier_gate_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] in_mode;
  logic       out_ready;
  logic [7:0] exp_data;
  logic       lat_arm;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one cycle of stimulus; inputs change just after the rising edge
  // so the monitors see them settled on the falling edge.
  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] m, input logic [7:0] e, input logic ordy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_mode   = m;
    exp_data  = e;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 8'h00, 2'b00, 8'h00, ordy);
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int S = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);

    hier_gate_pipe_if #(.WIDTH(8)) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.in_a      = in_a;
    assign bus.in_b      = in_b;
    assign bus.in_mode   = in_mode;
    assign bus.out_ready = out_ready;

    hier_gate_pipe #(.WIDTH(8), .STAGES(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    logic [7:0]  q[$];
    logic [15:0] cnt_model = 16'd0;
    logic        rst_d     = 1'b0;
    logic        stall_d   = 1'b0;
    logic [7:0]  held      = 8'h00;
    logic        lat_wait  = 1'b0;
    int          lat       = 0;
    logic        exp_rdy;
    logic [7:0]  exp_out;

    always @(negedge clk) begin
      if (rst_d) begin
        checkOutput($sformatf("S%0d post_reset_out_valid", S), bus.out_valid, 1'b0);
        checkOutput($sformatf("S%0d post_reset_beat_count", S), bus.beat_count, 16'd0);
        checkOutput($sformatf("S%0d post_reset_out_data", S), bus.out_data, 8'h00);
        checkOutput($sformatf("S%0d post_reset_out_zero", S), bus.out_zero, 1'b0);
      end

      exp_rdy = !rst && (out_ready || (q.size() < S));
      checkOutput($sformatf("S%0d in_ready", S), bus.in_ready, exp_rdy);
      checkOutput($sformatf("S%0d beat_count", S), bus.beat_count, cnt_model);

      if (stall_d && bus.out_valid)
        checkOutput($sformatf("S%0d stall_hold", S), bus.out_data, held);

      if (rst) begin
        lat_wait = 1'b0;
      end else if (lat_wait) begin
        if (bus.out_valid) begin
          checkOutput($sformatf("S%0d latency", S), lat, S - 1);
          lat_wait = 1'b0;
        end else if (lat >= 8) begin
          checkOutput($sformatf("S%0d latency_timeout", S), lat, S - 1);
          lat_wait = 1'b0;
        end else begin
          lat++;
        end
      end

      if (rst) begin
        q.delete();
        cnt_model = 16'd0;
      end else begin
        if (bus.out_valid && q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL S%0d spurious_out_valid: got data %0h, expected no beat", S, bus.out_data);
        end else if (bus.out_valid && out_ready) begin
          exp_out = q.pop_front();
          checkOutput($sformatf("S%0d out_data", S), bus.out_data, exp_out);
          checkOutput($sformatf("S%0d out_zero", S), bus.out_zero, exp_out == 8'h00);
          if (cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
        end
        if (in_valid && bus.in_ready) begin
          q.push_back(exp_data);
          if (lat_arm) begin
            lat_wait = 1'b1;
            lat      = 0;
          end
        end
      end

      stall_d = !rst && bus.out_valid && !out_ready;
      held    = bus.out_data;
      rst_d   = rst;
    end
  end

  initial begin
    rst       = 1'b1;
    lat_arm   = 1'b0;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    in_mode   = 2'b00;
    exp_data  = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single beat through an empty pipe: data, zero flag and latency.
    lat_arm = 1'b1;
    applyStimulus(1'b1, 8'hF0, 8'hFF, 2'b00, 8'h0F, 1'b1);
    lat_arm = 1'b0;
    idle(5, 1'b1);

    // Back-to-back beats, one per mode change.
    applyStimulus(1'b1, 8'hA5, 8'h5A, 2'b01, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'hA5, 8'h5A, 2'b10, 8'hFF, 1'b1);
    applyStimulus(1'b1, 8'hA5, 8'h5A, 2'b11, 8'hFF, 1'b1);
    idle(5, 1'b1);

    // Continuous stream into a stalled output, then drain.
    applyStimulus(1'b1, 8'h3C, 8'h0F, 2'b11, 8'h33, 1'b0);
    applyStimulus(1'b1, 8'h3C, 8'h0F, 2'b01, 8'h0C, 1'b0);
    applyStimulus(1'b1, 8'h3C, 8'h0F, 2'b10, 8'h3F, 1'b0);
    applyStimulus(1'b1, 8'h3C, 8'h0F, 2'b00, 8'h03, 1'b0);
    applyStimulus(1'b1, 8'hFF, 8'hFF, 2'b11, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h00, 8'h00, 2'b10, 8'h00, 1'b0);
    idle(6, 1'b1);

    // Fill, then simultaneous in/out transfers while full.
    applyStimulus(1'b1, 8'h12, 8'h34, 2'b01, 8'h10, 1'b0);
    applyStimulus(1'b1, 8'h12, 8'h34, 2'b10, 8'h36, 1'b0);
    applyStimulus(1'b1, 8'h12, 8'h34, 2'b11, 8'h26, 1'b0);
    applyStimulus(1'b1, 8'h12, 8'h34, 2'b00, 8'h24, 1'b0);
    applyStimulus(1'b1, 8'hC0, 8'h0C, 2'b10, 8'hCC, 1'b1);
    applyStimulus(1'b1, 8'hC0, 8'h0C, 2'b11, 8'hCC, 1'b1);
    applyStimulus(1'b1, 8'hC0, 8'h0C, 2'b01, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'hC0, 8'h0C, 2'b00, 8'h0C, 1'b1);
    idle(6, 1'b1);

    // Reset with beats in flight; the next beat must see normal latency.
    applyStimulus(1'b1, 8'hAA, 8'h55, 2'b10, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'hAA, 8'h55, 2'b01, 8'h00, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h11, 8'h22, 2'b10, 8'h33, 1'b1);
    rst = 1'b0;
    lat_arm = 1'b1;
    applyStimulus(1'b1, 8'h0F, 8'hF0, 2'b11, 8'hFF, 1'b1);
    lat_arm = 1'b0;
    idle(6, 1'b1);

    // Push beat_count past 16'hFFFF to exercise saturation.
    $display("[TB] saturating beat_count");
    for (int i = 0; i < 65540; i++) applyStimulus(1'b1, 8'h81, 8'h18, 2'b11, 8'h99, 1'b1);
    idle(6, 1'b1);

    checkOutput("S2 beat_count_saturated", g_cfg[0].bus.beat_count, 16'hFFFF);
    checkOutput("S1 beat_count_saturated", g_cfg[1].bus.beat_count, 16'hFFFF);
    checkOutput("S4 beat_count_saturated", g_cfg[2].bus.beat_count, 16'hFFFF);
    checkOutput("S2 drained", g_cfg[0].q.size(), 0);
    checkOutput("S1 drained", g_cfg[1].q.size(), 0);
    checkOutput("S4 drained", g_cfg[2].q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
